// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : decode_queue
// Brief    : Show-ahead circular instruction buffer between fetch and decode.
//            Entries carry predecode flags, and a flush empties the buffer.
// Revision : 1.0 - initial release
// ============================================================================
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_instruction,
    input  logic [WIDTH-1:0] in_pc_plus_four,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instruction,
    output logic [WIDTH-1:0] out_pc_plus_four,
    output logic             out_is_branch,
    output logic             out_is_mf,
    output logic             out_is_div,
    input  logic             flush,
    output logic [CW-1:0]    count
);

    localparam int          PW      = $clog2(DEPTH);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    logic [WIDTH-1:0] instr_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [2:0]       flag_mem  [DEPTH];

    logic             push;
    logic             pop;
    logic [5:0]       op;
    logic [5:0]       funct;
    logic [2:0]       in_flags;
    logic             unused_instr_bits;

    assign in_ready  = (count_q < C_DEPTH);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push = in_valid  & in_ready  & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    assign op                = in_instruction[31:26];
    assign funct             = in_instruction[5:0];
    assign unused_instr_bits = ^in_instruction[25:6];

    // Flag vector layout: {is_branch, is_mf, is_div}
    always_comb begin
        in_flags = 3'b000;
        if (op >= 6'h01 && op <= 6'h07) begin
            in_flags[2] = 1'b1;
        end
        if (op == 6'h00) begin
            in_flags[2] = (funct == 6'h08) || (funct == 6'h09);
            in_flags[1] = (funct == 6'h10) || (funct == 6'h12);
            in_flags[0] = (funct == 6'h1A) || (funct == 6'h1B);
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clock) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= in_instruction;
            pc_mem[wr_ptr_q]    <= in_pc_plus_four;
            flag_mem[wr_ptr_q]  <= in_flags;
        end
    end

    always_comb begin
        out_instruction  = '0;
        out_pc_plus_four = '0;
        out_is_branch    = 1'b0;
        out_is_mf        = 1'b0;
        out_is_div       = 1'b0;
        if (out_valid) begin
            out_instruction  = instr_mem[rd_ptr_q];
            out_pc_plus_four = pc_mem[rd_ptr_q];
            out_is_branch    = flag_mem[rd_ptr_q][2];
            out_is_mf        = flag_mem[rd_ptr_q][1];
            out_is_div       = flag_mem[rd_ptr_q][0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_queue
// Brief    : Directed vector bench for decode_queue (DEPTH = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_instruction = '0;
    logic [WIDTH-1:0] in_pc_plus_four = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_instruction;
    logic [WIDTH-1:0] out_pc_plus_four;
    logic             out_is_branch;
    logic             out_is_mf;
    logic             out_is_div;
    logic             flush = 1'b0;
    logic [CW-1:0]    count;

    int checks   = 0;
    int failures = 0;

    decode_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_instruction   (in_instruction),
        .in_pc_plus_four  (in_pc_plus_four),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instruction  (out_instruction),
        .out_pc_plus_four (out_pc_plus_four),
        .out_is_branch    (out_is_branch),
        .out_is_mf        (out_is_mf),
        .out_is_div       (out_is_div),
        .flush            (flush),
        .count            (count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic        r;
        logic        f;
        logic [31:0] instr;
        int          exp_count;
        logic [31:0] exp_instr;
        logic [2:0]  exp_flags;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] pc_of(input logic [31:0] instr);
        return instr ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_state(input int idx, input int ec, input logic [31:0] ei, input logic [2:0] ef);
        logic [31:0] epc;
        epc = (ec != 0) ? pc_of(ei) : 32'h0;
        chk("count",     idx, 32'(count), 32'(ec));
        chk("out_valid", idx, 32'(out_valid), (ec != 0) ? 32'd1 : 32'd0);
        chk("in_ready",  idx, 32'(in_ready),  (ec < DEPTH) ? 32'd1 : 32'd0);
        chk("out_instr", idx, out_instruction, ei);
        chk("out_pc",    idx, out_pc_plus_four, epc);
        chk("flags",     idx, {29'b0, out_is_branch, out_is_mf, out_is_div}, {29'b0, ef});
    endtask

    task automatic add(input logic v, input logic r, input logic f, input logic [31:0] instr,
                       input int ec, input logic [31:0] ei, input logic [2:0] ef);
        vec_t t;
        t.v = v; t.r = r; t.f = f; t.instr = instr;
        t.exp_count = ec; t.exp_instr = ei; t.exp_flags = ef;
        vecs.push_back(t);
    endtask

    task automatic drive_cycle(input logic v, input logic r, input logic f, input logic [31:0] instr);
        @(negedge clock);
        in_valid        = v;
        out_ready       = r;
        flush           = f;
        in_instruction  = instr;
        in_pc_plus_four = pc_of(instr);
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Fill, full refusal (also with a pop), wrap, drain, empty pop
        add(1, 0, 0, 32'h8C220004, 1, 32'h8C220004, 3'b000);
        add(1, 0, 0, 32'h20010002, 2, 32'h8C220004, 3'b000);
        add(1, 0, 0, 32'h20010003, 3, 32'h8C220004, 3'b000);
        add(1, 0, 0, 32'h20010004, 4, 32'h8C220004, 3'b000);
        add(1, 0, 0, 32'h20010005, 4, 32'h8C220004, 3'b000);
        add(0, 1, 0, 32'h0,        3, 32'h20010002, 3'b000);
        add(0, 1, 0, 32'h0,        2, 32'h20010003, 3'b000);
        add(1, 0, 0, 32'h20010006, 3, 32'h20010003, 3'b000);
        add(1, 0, 0, 32'h20010007, 4, 32'h20010003, 3'b000);
        add(1, 1, 0, 32'h200100FF, 3, 32'h20010004, 3'b000);
        add(0, 1, 0, 32'h0,        2, 32'h20010006, 3'b000);
        add(0, 1, 0, 32'h0,        1, 32'h20010007, 3'b000);
        add(0, 1, 0, 32'h0,        0, 32'h0,        3'b000);
        add(0, 1, 0, 32'h0,        0, 32'h0,        3'b000);
        // Predecode flags and simultaneous push/pop at count 2
        add(1, 0, 0, 32'h10850003, 1, 32'h10850003, 3'b100);
        add(1, 0, 0, 32'h00001010, 2, 32'h10850003, 3'b100);
        add(1, 1, 0, 32'h0085001A, 2, 32'h00001010, 3'b010);
        add(1, 1, 0, 32'h03E00008, 2, 32'h0085001A, 3'b001);
        add(0, 1, 0, 32'h0,        1, 32'h03E00008, 3'b100);
        add(1, 0, 0, 32'h00000009, 2, 32'h03E00008, 3'b100);
        add(1, 1, 0, 32'h00000011, 2, 32'h00000009, 3'b100);
        add(1, 0, 0, 32'h0000001B, 3, 32'h00000009, 3'b100);
        // Flush beats push and pop; next-cycle push accepted normally
        add(1, 1, 1, 32'hDEADBEEF, 0, 32'h0,        3'b000);
        add(1, 0, 0, 32'h00000012, 1, 32'h00000012, 3'b010);
        add(0, 1, 0, 32'h0,        0, 32'h0,        3'b000);
        add(1, 0, 0, 32'h00000011, 1, 32'h00000011, 3'b000);
        add(0, 1, 0, 32'h0,        0, 32'h0,        3'b000);
        add(1, 0, 0, 32'h0000001A, 1, 32'h0000001A, 3'b001);
        add(0, 1, 0, 32'h0,        0, 32'h0,        3'b000);

        repeat (2) @(posedge clock);
        #1;
        chk_state(-1, 0, 32'h0, 3'b000);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk_state(-2, 0, 32'h0, 3'b000);

        foreach (vecs[i]) begin
            drive_cycle(vecs[i].v, vecs[i].r, vecs[i].f, vecs[i].instr);
            chk_state(i, vecs[i].exp_count, vecs[i].exp_instr, vecs[i].exp_flags);
        end

        // Asynchronous reset between edges with three entries held
        drive_cycle(1, 0, 0, 32'h24020001);
        drive_cycle(1, 0, 0, 32'h24020002);
        drive_cycle(1, 0, 0, 32'h24020003);
        chk_state(100, 3, 32'h24020001, 3'b000);
        @(negedge clock);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk_state(101, 0, 32'h0, 3'b000);
        @(negedge clock);
        reset_n = 1'b1;
        drive_cycle(1, 0, 0, 32'h10000004);
        chk_state(102, 1, 32'h10000004, 3'b100);
        drive_cycle(0, 1, 0, 32'h0);
        chk_state(103, 0, 32'h0, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
